// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED bank driver: manual pattern plus a 4-entry pattern table stepped by a timer.
// Latency: out_port registered, 1 cycle after any state/idx/register change; reads combinational.
// Backpressure: none; zero wait states, every write is accepted on the clock edge it is presented.
module led_pattern_sequencer #(
   parameter int LED_W = 10,
   parameter int PER_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] out_port
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [LED_W-1:0] data_reg;
   logic [LED_W-1:0] pat [4];
   logic [PER_W-1:0] period_reg;
   logic [PER_W-1:0] timer;
   logic             ctrl_run;
   logic             ctrl_oneshot;
   logic [1:0]       ctrl_last;
   logic             done_flag;
   logic [1:0]       state;
   logic [1:0]       idx;

   logic wr;
   logic wr_data;
   logic wr_ctrl;
   logic wr_period;
   logic wr_status;
   logic wr_pat;
   logic busy;
   logic step_due;
   logic at_last;
   logic unused_wdata;

   assign wr        = chipselect & ~write_n;
   assign wr_data   = wr & (address == 3'd0);
   assign wr_ctrl   = wr & (address == 3'd1);
   assign wr_period = wr & (address == 3'd2);
   assign wr_status = wr & (address == 3'd3);
   assign wr_pat    = wr & address[2];

   assign busy     = (state == ST_RUN);
   // Compare is >= so shrinking PERIOD below the running timer advances immediately.
   assign step_due = (timer >= period_reg);
   // An idx beyond a newly written last is treated as the final step.
   assign at_last  = (idx >= ctrl_last);

   // Upper writedata bits are deliberately ignored.
   assign unused_wdata = ^writedata;

   // Plain software-owned registers: manual pattern, step period, pattern table.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg   <= '0;
         period_reg <= '0;
         for (int i = 0; i < 4; i++) pat[i] <= '0;
      end else begin
         if (wr_data)   data_reg   <= writedata[LED_W-1:0];
         if (wr_period) period_reg <= writedata[PER_W-1:0];
         if (wr_pat)    pat[address[1:0]] <= writedata[LED_W-1:0];
      end
   end

   // Sequencer FSM with CTRL and the sticky done flag, which hardware also updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_run     <= 1'b0;
         ctrl_oneshot <= 1'b0;
         ctrl_last    <= 2'd0;
         done_flag    <= 1'b0;
         state        <= ST_IDLE;
         idx          <= 2'd0;
         timer        <= '0;
      end else begin
         // Software clear first so a same-cycle hardware set below wins.
         if (wr_status && writedata[1]) done_flag <= 1'b0;

         if (wr_ctrl) begin
            // Any CTRL write restarts from step 0 (run=1) or returns to the manual pattern.
            ctrl_run     <= writedata[0];
            ctrl_oneshot <= writedata[1];
            ctrl_last    <= writedata[3:2];
            idx          <= 2'd0;
            timer        <= '0;
            state        <= writedata[0] ? ST_RUN : ST_IDLE;
         end else if (state == ST_RUN) begin
            if (step_due) begin
               timer <= '0;
               if (!at_last) begin
                  idx <= idx + 2'd1;
               end else if (!ctrl_oneshot) begin
                  idx <= 2'd0;
               end else begin
                  state     <= ST_DONE;
                  done_flag <= 1'b1;
                  ctrl_run  <= 1'b0;
               end
            end else begin
               timer <= timer + PER_W'(1);
            end
         end
      end
   end

   // LED drive register: selected source depends on the sequencer state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_port <= '0;
      end else begin
         case (state)
            ST_RUN:  out_port <= pat[idx];
            ST_DONE: out_port <= pat[ctrl_last];
            default: out_port <= data_reg;
         endcase
      end
   end

   // Combinational read mux; unused bits read zero.
   always_comb begin
      readdata = '0;
      case (address)
         3'd0: readdata[LED_W-1:0] = data_reg;
         3'd1: readdata[3:0] = {ctrl_last, ctrl_oneshot, ctrl_run};
         3'd2: readdata[PER_W-1:0] = period_reg;
         3'd3: begin
            readdata[0]   = busy;
            readdata[1]   = done_flag;
            readdata[5:4] = idx;
         end
         default: readdata[LED_W-1:0] = pat[address[1:0]];
      endcase
   end

endmodule
